// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit.
// lc3b_word / bru_entry_t describe a queued prediction; CF_* are the
// control-flow op encodings carried on the resolve and update ports.
package branch_resolve_unit_pkg;

   typedef logic [15:0] lc3b_word;

   typedef struct packed {
      lc3b_word pc;
      logic     taken;
      lc3b_word target;
   } bru_entry_t;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_RECOVER = 1'b1
   } bru_state_e;

   localparam logic [3:0] CF_NONE   = 4'd0;
   localparam logic [3:0] CF_BRANCH = 4'd1;
   localparam logic [3:0] CF_JMP    = 4'd2;
   localparam logic [3:0] CF_JSR    = 4'd3;
   localparam logic [3:0] CF_TRAP   = 4'd4;

endpackage

// File: rtl/branch_resolve_unit_pred_fifo.sv
// pred_fifo: in-order queue of fetch-time predictions.
// Head (rdata) is the oldest entry and is read combinationally.
// clear empties the queue and takes priority over push/pop.
// A push while full is only taken when a pop happens in the same cycle.
module pred_fifo
   import branch_resolve_unit_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int PTR_BITS = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                push,
   input  bru_entry_t          wdata,
   input  logic                pop,
   input  logic                clear,
   output bru_entry_t          rdata,
   output logic                full,
   output logic                empty,
   output logic [PTR_BITS:0]   count
);

   localparam int CNT_W = PTR_BITS + 1;

   bru_entry_t            mem [DEPTH];
   logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  push_ok;
   logic                  pop_ok;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem[rd_ptr_q];
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   // Next pointer/count values; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage; no reset needed since count gates validity.
   always_ff @(posedge clk) begin
      if (push_ok && !clear) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: pairs each resolved control-flow instruction with
// its fetch-time prediction, drives the predictor update port and issues a
// one-cycle redirect on a misprediction.
// Optional macro BRU_STATS_EN adds saturating stat_resolved and
// stat_mispredicts counters.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int PTR_BITS = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        push,
   input  logic [15:0] push_pc,
   input  logic        push_taken,
   input  logic [15:0] push_target,
   output logic        push_ready,
   input  logic        resolve,
   input  logic [3:0]  resolve_op,
   input  logic        resolve_taken,
   input  logic [15:0] resolve_target,
   output logic        update,
   output logic        update_is_branch,
   output logic        update_taken,
   output logic [15:0] update_pc,
   output logic [15:0] update_target,
   output logic [3:0]  update_op,
   output logic        redirect,
   output logic [15:0] redirect_pc,
   output logic        err
`ifdef BRU_STATS_EN
   ,
   output logic [15:0] stat_resolved,
   output logic [15:0] stat_mispredicts
`endif
);

   localparam int CNT_W = PTR_BITS + 1;

   bru_state_e        state_q, state_d;
   logic              rdy_q, rdy_d;
   logic              err_q, err_d;
   logic              update_q, update_d;
   logic              update_is_branch_q, update_is_branch_d;
   logic              update_taken_q, update_taken_d;
   lc3b_word          update_pc_q, update_pc_d;
   lc3b_word          update_target_q, update_target_d;
   logic [3:0]        update_op_q, update_op_d;
   logic              redirect_q, redirect_d;
   lc3b_word          redirect_pc_q, redirect_pc_d;

   bru_entry_t        head;
   bru_entry_t        push_entry;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_clear;
   logic              res_valid;
   logic              mispredict;
   logic              push_err;
   lc3b_word          correct_pc;

   assign push_entry = '{pc: push_pc, taken: push_taken, target: push_target};

   pred_fifo #(
      .DEPTH    (DEPTH),
      .PTR_BITS (PTR_BITS)
   ) u_pred_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (fifo_push),
      .wdata   (push_entry),
      .pop     (fifo_pop),
      .clear   (fifo_clear),
      .rdata   (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // rdy_q holds push_ready low for the first cycle out of reset.
   assign push_ready = rdy_q && (state_q == ST_RUN) && (fifo_count != CNT_W'(DEPTH));

   // Resolve/compare, queue control, FSM next state and next outputs.
   always_comb begin
      res_valid  = resolve && (state_q == ST_RUN) && !fifo_empty;
      mispredict = res_valid &&
                   ((resolve_taken != head.taken) ||
                    (resolve_taken && (resolve_target != head.target)));
      correct_pc = resolve_taken ? resolve_target : (head.pc + 16'd2);

      // A push alongside a correct resolve is legal even when full; a push
      // alongside a mispredict is wrong-path and silently dropped.
      push_err   = push && (state_q == ST_RUN) && !push_ready && !res_valid;
      fifo_push  = push && (state_q == ST_RUN) && !mispredict && (push_ready || res_valid);
      fifo_pop   = res_valid && !mispredict;
      fifo_clear = mispredict;

      state_d = state_q;
      case (state_q)
         ST_RUN:     if (mispredict) state_d = ST_RECOVER;
         ST_RECOVER: state_d = ST_RUN;
         default:    state_d = ST_RUN;
      endcase

      rdy_d = 1'b1;
      // Resolve with nothing to pair against (empty or recovering) is an error.
      err_d = err_q || push_err || (resolve && !res_valid);

      update_d           = res_valid;
      update_is_branch_d = res_valid && (resolve_op == CF_BRANCH);
      update_taken_d     = res_valid && resolve_taken;
      update_pc_d        = res_valid ? head.pc : 16'h0000;
      update_target_d    = res_valid ? resolve_target : 16'h0000;
      update_op_d        = res_valid ? resolve_op : CF_NONE;
      redirect_d         = mispredict;
      redirect_pc_d      = mispredict ? correct_pc : 16'h0000;
   end

   // Control and registered output state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q            <= ST_RUN;
         rdy_q              <= 1'b0;
         err_q              <= 1'b0;
         update_q           <= 1'b0;
         update_is_branch_q <= 1'b0;
         update_taken_q     <= 1'b0;
         update_pc_q        <= 16'h0000;
         update_target_q    <= 16'h0000;
         update_op_q        <= 4'h0;
         redirect_q         <= 1'b0;
         redirect_pc_q      <= 16'h0000;
      end else begin
         state_q            <= state_d;
         rdy_q              <= rdy_d;
         err_q              <= err_d;
         update_q           <= update_d;
         update_is_branch_q <= update_is_branch_d;
         update_taken_q     <= update_taken_d;
         update_pc_q        <= update_pc_d;
         update_target_q    <= update_target_d;
         update_op_q        <= update_op_d;
         redirect_q         <= redirect_d;
         redirect_pc_q      <= redirect_pc_d;
      end
   end

   assign update           = update_q;
   assign update_is_branch = update_is_branch_q;
   assign update_taken     = update_taken_q;
   assign update_pc        = update_pc_q;
   assign update_target    = update_target_q;
   assign update_op        = update_op_q;
   assign redirect         = redirect_q;
   assign redirect_pc      = redirect_pc_q;
   assign err              = err_q;

`ifdef BRU_STATS_EN
   function automatic lc3b_word sat_inc16(input lc3b_word v);
      return (v == 16'hFFFF) ? v : (v + 16'd1);
   endfunction

   lc3b_word stat_resolved_q, stat_resolved_d;
   lc3b_word stat_mispredicts_q, stat_mispredicts_d;

   // Counters advance on each update pulse; mispredicts count redirects.
   always_comb begin
      stat_resolved_d    = update_q ? sat_inc16(stat_resolved_q) : stat_resolved_q;
      stat_mispredicts_d = redirect_q ? sat_inc16(stat_mispredicts_q) : stat_mispredicts_q;
   end

   // Statistics counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_resolved_q    <= 16'h0000;
         stat_mispredicts_q <= 16'h0000;
      end else begin
         stat_resolved_q    <= stat_resolved_d;
         stat_mispredicts_q <= stat_mispredicts_d;
      end
   end

   assign stat_resolved    = stat_resolved_q;
   assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit (DEPTH=4).
module tb_branch_resolve_unit;
   import branch_resolve_unit_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        push;
   logic [15:0] push_pc;
   logic        push_taken;
   logic [15:0] push_target;
   logic        push_ready;
   logic        resolve;
   logic [3:0]  resolve_op;
   logic        resolve_taken;
   logic [15:0] resolve_target;
   logic        update;
   logic        update_is_branch;
   logic        update_taken;
   logic [15:0] update_pc;
   logic [15:0] update_target;
   logic [3:0]  update_op;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        err;
`ifdef BRU_STATS_EN
   logic [15:0] stat_resolved;
   logic [15:0] stat_mispredicts;
`endif

   int checks   = 0;
   int failures = 0;

   branch_resolve_unit #(.DEPTH(4), .PTR_BITS(2)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .push             (push),
      .push_pc          (push_pc),
      .push_taken       (push_taken),
      .push_target      (push_target),
      .push_ready       (push_ready),
      .resolve          (resolve),
      .resolve_op       (resolve_op),
      .resolve_taken    (resolve_taken),
      .resolve_target   (resolve_target),
      .update           (update),
      .update_is_branch (update_is_branch),
      .update_taken     (update_taken),
      .update_pc        (update_pc),
      .update_target    (update_target),
      .update_op        (update_op),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc),
      .err              (err)
`ifdef BRU_STATS_EN
      ,
      .stat_resolved    (stat_resolved),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      push           = 1'b0;
      push_pc        = 16'h0000;
      push_taken     = 1'b0;
      push_target    = 16'h0000;
      resolve        = 1'b0;
      resolve_op     = CF_NONE;
      resolve_taken  = 1'b0;
      resolve_target = 16'h0000;
   endtask

   task automatic drive_push(input logic [15:0] pc, input logic tk, input logic [15:0] tg);
      push        = 1'b1;
      push_pc     = pc;
      push_taken  = tk;
      push_target = tg;
   endtask

   task automatic drive_resolve(input logic [3:0] op, input logic tk, input logic [15:0] tg);
      resolve        = 1'b1;
      resolve_op     = op;
      resolve_taken  = tk;
      resolve_target = tg;
   endtask

   // Reset pulse applied off the clock edge; leaves the DUT one cycle past release.
   task automatic pulse_reset();
      idle();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      #2;
      checks++; if (update !== 1'b0) begin failures++; $display("FAIL rst_update got=%0b exp=0", update); end
      checks++; if (redirect !== 1'b0 || redirect_pc !== 16'h0000) begin failures++; $display("FAIL rst_redirect got=%0b/%h exp=0/0000", redirect, redirect_pc); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", err); end
      checks++; if (push_ready !== 1'b0) begin failures++; $display("FAIL rst_push_ready got=%0b exp=0", push_ready); end
      step();
      reset_n = 1'b1;
      #1;
      checks++; if (push_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_release got=%0b exp=0", push_ready); end
      step();
      checks++; if (push_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_rise got=%0b exp=1", push_ready); end
   endtask

   task automatic test_correct_predict();
      drive_push(16'h3000, 1'b1, 16'h3010);
      step();
      idle();
      drive_resolve(CF_BRANCH, 1'b1, 16'h3010);
      step();
      idle();
      checks++; if (update !== 1'b1 || update_is_branch !== 1'b1) begin failures++; $display("FAIL cp_update got=%0b/%0b exp=1/1", update, update_is_branch); end
      checks++; if (update_pc !== 16'h3000 || update_target !== 16'h3010 || update_taken !== 1'b1 || update_op !== CF_BRANCH) begin
         failures++; $display("FAIL cp_fields got=%h/%h/%0b/%h exp=3000/3010/1/1", update_pc, update_target, update_taken, update_op); end
      checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL cp_redirect got=%0b exp=0", redirect); end
      step();
      checks++; if (update !== 1'b0) begin failures++; $display("FAIL cp_one_cycle got=%0b exp=0", update); end
   endtask

   task automatic test_mispredict();
      drive_push(16'h3000, 1'b0, 16'h0000);
      step();
      idle();
      drive_resolve(CF_BRANCH, 1'b1, 16'h3040);
      step();
      idle();
      checks++; if (redirect !== 1'b1 || redirect_pc !== 16'h3040) begin failures++; $display("FAIL mp_redirect got=%0b/%h exp=1/3040", redirect, redirect_pc); end
      checks++; if (update !== 1'b1) begin failures++; $display("FAIL mp_update got=%0b exp=1", update); end
      checks++; if (push_ready !== 1'b0) begin failures++; $display("FAIL mp_recover_ready got=%0b exp=0", push_ready); end
      drive_push(16'h5555, 1'b0, 16'h0000);
      step();
      idle();
      checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL mp_pulse got=%0b exp=0", redirect); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL mp_recover_err got=%0b exp=0", err); end
      checks++; if (push_ready !== 1'b1) begin failures++; $display("FAIL mp_run_ready got=%0b exp=1", push_ready); end
      drive_push(16'h4000, 1'b0, 16'h0000);
      step();
      idle();
      drive_resolve(CF_JMP, 1'b0, 16'h0000);
      step();
      idle();
      checks++; if (update_pc !== 16'h4000 || update_is_branch !== 1'b0 || update_op !== CF_JMP) begin
         failures++; $display("FAIL mp_dropped_push got=%h/%0b/%h exp=4000/0/2", update_pc, update_is_branch, update_op); end
      checks++; if (redirect !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL mp_after got=%0b/%0b exp=0/0", redirect, err); end
   endtask

   task automatic test_wrap();
      drive_push(16'hFFFE, 1'b1, 16'h1234);
      step();
      idle();
      drive_resolve(CF_BRANCH, 1'b0, 16'h0000);
      step();
      idle();
      checks++; if (redirect !== 1'b1 || redirect_pc !== 16'h0000) begin failures++; $display("FAIL wrap_pc got=%0b/%h exp=1/0000", redirect, redirect_pc); end
      checks++; if (update_taken !== 1'b0 || update_pc !== 16'hFFFE) begin failures++; $display("FAIL wrap_update got=%0b/%h exp=0/fffe", update_taken, update_pc); end
      step();
   endtask

   task automatic test_full_and_back_to_back();
      logic [15:0] exp_pc;
      for (int i = 0; i < 4; i++) begin
         drive_push(16'h0100 + 16'(2 * i), 1'b0, 16'h0000);
         step();
      end
      idle();
      checks++; if (push_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", push_ready); end
      drive_push(16'h0108, 1'b0, 16'h0000);
      drive_resolve(CF_BRANCH, 1'b0, 16'h0000);
      step();
      idle();
      checks++; if (update !== 1'b1 || update_pc !== 16'h0100 || redirect !== 1'b0) begin
         failures++; $display("FAIL full_pushpop got=%0b/%h/%0b exp=1/0100/0", update, update_pc, redirect); end
      checks++; if (push_ready !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL full_count got=%0b/%0b exp=0/0", push_ready, err); end
      drive_push(16'h010A, 1'b0, 16'h0000);
      step();
      idle();
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL full_push_err got=%0b exp=1", err); end
      drive_resolve(CF_BRANCH, 1'b0, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         step();
         exp_pc = 16'h0102 + 16'(2 * i);
         checks++; if (update !== 1'b1 || update_pc !== exp_pc) begin
            failures++; $display("FAIL b2b_%0d got=%0b/%h exp=1/%h", i, update, update_pc, exp_pc); end
      end
      idle();
      step();
      checks++; if (push_ready !== 1'b1 || update !== 1'b0) begin failures++; $display("FAIL drained got=%0b/%0b exp=1/0", push_ready, update); end
      pulse_reset();
   endtask

   task automatic test_empty_resolve();
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL empty_pre_err got=%0b exp=0", err); end
      drive_resolve(CF_BRANCH, 1'b1, 16'h2000);
      step();
      idle();
      checks++; if (update !== 1'b0 || redirect !== 1'b0) begin failures++; $display("FAIL empty_update got=%0b/%0b exp=0/0", update, redirect); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL empty_err got=%0b exp=1", err); end
   endtask

   task automatic test_reset_mid_recover();
      drive_push(16'h6000, 1'b1, 16'h6100);
      step();
      idle();
      drive_resolve(CF_BRANCH, 1'b1, 16'h6200);
      step();
      idle();
      checks++; if (redirect !== 1'b1 || redirect_pc !== 16'h6200) begin failures++; $display("FAIL mr_redirect got=%0b/%h exp=1/6200", redirect, redirect_pc); end
      reset_n = 1'b0;
      #1;
      checks++; if (update !== 1'b0 || redirect !== 1'b0 || redirect_pc !== 16'h0000 || update_pc !== 16'h0000) begin
         failures++; $display("FAIL mr_outputs got=%0b/%0b/%h/%h exp=0/0/0000/0000", update, redirect, redirect_pc, update_pc); end
      checks++; if (err !== 1'b0 || push_ready !== 1'b0) begin failures++; $display("FAIL mr_err got=%0b/%0b exp=0/0", err, push_ready); end
      #1;
      reset_n = 1'b1;
      step();
      checks++; if (push_ready !== 1'b1) begin failures++; $display("FAIL mr_run_ready got=%0b exp=1", push_ready); end
      drive_push(16'h7000, 1'b0, 16'h0000);
      step();
      idle();
      drive_resolve(CF_JSR, 1'b0, 16'h0000);
      step();
      idle();
      checks++; if (update !== 1'b1 || update_pc !== 16'h7000 || err !== 1'b0) begin
         failures++; $display("FAIL mr_resume got=%0b/%h/%0b exp=1/7000/0", update, update_pc, err); end
   endtask

`ifdef BRU_STATS_EN
   task automatic test_stats();
      pulse_reset();
      checks++; if (stat_resolved !== 16'd0 || stat_mispredicts !== 16'd0) begin
         failures++; $display("FAIL st_reset got=%0d/%0d exp=0/0", stat_resolved, stat_mispredicts); end
      for (int i = 0; i < 3; i++) begin
         drive_push(16'h8000 + 16'(2 * i), 1'b1, 16'h9000);
         step();
         idle();
         drive_resolve(CF_BRANCH, 1'b1, 16'h9000);
         step();
         idle();
      end
      drive_push(16'hA000, 1'b0, 16'h0000);
      step();
      idle();
      for (int i = 0; i < 2; i++) begin
         drive_resolve(CF_BRANCH, 1'b1, 16'hB000);
         step();
         idle();
         step();
         drive_push(16'hA100 + 16'(2 * i), 1'b0, 16'h0000);
         step();
         idle();
      end
      step();
      step();
      checks++; if (stat_resolved !== 16'd5 || stat_mispredicts !== 16'd2) begin
         failures++; $display("FAIL st_counts got=%0d/%0d exp=5/2", stat_resolved, stat_mispredicts); end
   endtask
`endif

   initial begin
      reset_n = 1'b0;
      idle();
      test_reset();
      test_correct_predict();
      test_mispredict();
      test_wrap();
      test_full_and_back_to_back();
      test_empty_resolve();
      test_reset_mid_recover();
`ifdef BRU_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
